// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {a,b,c,d,e,f,g} patterns, indexed by hex nibble.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // A single-digit array still needs a one-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-synchronous data updates.
// Leading-zero suppression is built when SSD_LEADING_ZERO_BLANK_EN is defined.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned SCAN_DIV = 131072,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                  board_clk,
  input  logic                  Reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  load,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [N_DIGITS-1:0]   An,
  output logic [6:0]            Cath,
  output logic                  Dp,
  output logic                  frame_tick
);

  localparam int unsigned IdxW = idx_width(N_DIGITS);
  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_DIGITS - 1);

  logic [PreW-1:0]       presc_q, presc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic                  tick_q, tick_d;
  logic [4*N_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [N_DIGITS-1:0]   lz_q, lz_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            cath_q, cath_d;
  logic                  dp_q, dp_d;

  logic                  slot_end;
  logic                  slot_en;
  logic [N_DIGITS-1:0]   hide;
  logic [3:0]            sel_nib;
  logic [6:0]            sel_seg;

  // tick_q is precomputed from next state so it is high during the wrap cycle itself.
  always_comb begin
    slot_end = (presc_q == PreLast);
    presc_d  = slot_end ? '0 : presc_q + PreW'(1);
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
    pwm_d  = pwm_q + PWM_BITS'(1);
    tick_d = (presc_d == PreLast) && (idx_d == IdxLast);
  end

  // Using the pending next-state gives the load-on-wrap bypass for free.
  always_comb begin
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    if (load) begin
      pend_dig_d   = digits;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
    end
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (tick_q) begin
      act_dig_d   = pend_dig_d;
      act_dp_d    = pend_dp_d;
      act_blank_d = pend_blank_d;
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic lz_run;
  always_comb begin
    lz_d   = '0;
    lz_run = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      if (lz_run && (act_dig_d[4*i +: 4] == 4'h0) && !act_dp_d[i]) begin
        lz_d[i] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end
`else
  assign lz_d = '0;
`endif

  assign sel_nib = act_dig_q[{idx_q, 2'b00} +: 4];

  ssd_hex_decoder u_hex_decoder (
    .nibble_i (sel_nib),
    .seg_o    (sel_seg)
  );

  always_comb begin
    slot_en = (&brightness) || (pwm_q < brightness);
    hide    = act_blank_q | lz_q;
    an_d    = '1;
    if (slot_en && !hide[idx_q]) begin
      an_d[idx_q] = 1'b0;
    end
    cath_d = sel_seg;
    dp_d   = ~act_dp_q[idx_q];
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      tick_q       <= 1'b0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      lz_q         <= '0;
      an_q         <= '1;
      cath_q       <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      tick_q       <= tick_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      lz_q         <= lz_d;
      an_q         <= an_d;
      cath_q       <= cath_d;
      dp_q         <= dp_d;
    end
  end

  assign An         = an_q;
  assign Cath       = cath_q;
  assign Dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller: cycle-count reference model feeds a queue, a monitor checks.
module tb_ssd_scan_controller;

  localparam int unsigned N  = 4;
  localparam int unsigned S  = 4;
  localparam int unsigned PB = 4;
  localparam int unsigned P  = 1 << PB;

  logic            board_clk = 1'b0;
  logic            Reset;
  logic [4*N-1:0]  digits;
  logic [N-1:0]    dp_in;
  logic [N-1:0]    blank_in;
  logic            load;
  logic [PB-1:0]   brightness;
  logic [N-1:0]    An;
  logic [6:0]      Cath;
  logic            Dp;
  logic            frame_tick;

  ssd_scan_controller #(
    .N_DIGITS (N),
    .SCAN_DIV (S),
    .PWM_BITS (PB)
  ) dut (
    .board_clk  (board_clk),
    .Reset      (Reset),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .brightness (brightness),
    .An         (An),
    .Cath       (Cath),
    .Dp         (Dp),
    .frame_tick (frame_tick)
  );

  always #5 board_clk = ~board_clk;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   cath;
    logic         dp;
    logic         ft;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  logic [6:0] seg_ref [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: k counts clock edges since reset release; frames are N*S edges long.
  int             k;
  logic [4*N-1:0] m_pend_dig, m_act_dig;
  logic [N-1:0]   m_pend_dp, m_act_dp, m_pend_bl, m_act_bl;

  function automatic bit wrap_at(input int kk);
    return ((kk % S) == S - 1) && (((kk / S) % N) == N - 1);
  endfunction

  function automatic logic [N-1:0] lz_mask();
    logic [N-1:0] m;
    m = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    for (int i = N - 1; i > 0; i--) begin
      if (m_act_dig[4*i +: 4] != 4'h0 || m_act_dp[i]) break;
      m[i] = 1'b1;
    end
`endif
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Called just after a falling edge: drives one cycle of inputs and predicts the next output.
  task automatic cycle(input bit ld, input logic [4*N-1:0] d, input logic [N-1:0] dp,
                       input logic [N-1:0] bl, input logic [PB-1:0] br);
    exp_t         e;
    int           slot;
    int           pw;
    bit           en;
    logic [N-1:0] hidden;
    logic [3:0]   nib;
    load = ld; digits = d; dp_in = dp; blank_in = bl; brightness = br;
    slot   = (k / S) % N;
    pw     = k % P;
    en     = (int'(br) == P - 1) || (pw < int'(br));
    hidden = m_act_bl | lz_mask();
    e.an   = '1;
    if (en && !hidden[slot]) e.an[slot] = 1'b0;
    nib    = m_act_dig[slot*4 +: 4];
    e.cath = seg_ref[nib];
    e.dp   = ~m_act_dp[slot];
    e.ft   = wrap_at(k + 1);
    sb_q.push_back(e);
    if (ld) begin
      m_pend_dig = d; m_pend_dp = dp; m_pend_bl = bl;
    end
    if (wrap_at(k)) begin
      m_act_dig = m_pend_dig; m_act_dp = m_pend_dp; m_act_bl = m_pend_bl;
    end
    k++;
    @(negedge board_clk);
  endtask

  task automatic idle(input int n, input logic [PB-1:0] br);
    for (int i = 0; i < n; i++) cycle(1'b0, digits, dp_in, blank_in, br);
  endtask

  task automatic run_to_wrap(input logic [PB-1:0] br);
    for (int i = 0; i < N * S && !wrap_at(k); i++) idle(1, br);
  endtask

  // Asserted between edges so the asynchronous clear is visible before any clock.
  task automatic do_reset(input bit ld_during);
    #3;
    mon_en = 1'b0;
    Reset  = 1'b1;
    load   = ld_during;
    digits = 16'h8888;
    dp_in  = '1;
    blank_in = '0;
    #1;
    chk("reset_an", An, {N{1'b1}});
    chk("reset_cath", Cath, 7'h7F);
    chk("reset_dp", Dp, 1'b1);
    chk("reset_tick", frame_tick, 1'b0);
    repeat (3) @(negedge board_clk);
    Reset = 1'b0;
    load  = 1'b0;
    sb_q.delete();
    k = 0;
    m_pend_dig = '0; m_act_dig = '0;
    m_pend_dp  = '0; m_act_dp  = '0;
    m_pend_bl  = '1; m_act_bl  = '1;
    #1;
    chk("post_reset_an", An, {N{1'b1}});
    chk("post_reset_cath", Cath, 7'h7F);
    mon_en = 1'b1;
  endtask

  function automatic logic [4*N-1:0] rand_digits();
    logic [4*N-1:0] d;
    for (int i = 0; i < N; i++) begin
      d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return d;
  endfunction

  initial begin
    forever begin
      @(posedge board_clk);
      #2;
      if (mon_en && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        if ({An, Cath, Dp, frame_tick} !== mon_e) begin
          failures++;
          $display("FAIL scan_out got An=%b Cath=%b Dp=%b tick=%b expected An=%b Cath=%b Dp=%b tick=%b at %0t",
                   An, Cath, Dp, frame_tick, mon_e.an, mon_e.cath, mon_e.dp, mon_e.ft, $time);
        end
      end
    end
  end

  initial begin
    Reset = 1'b0; load = 1'b0; digits = '0; dp_in = '0; blank_in = '0; brightness = '1;
    @(negedge board_clk);
    do_reset(1'b1);

    // Dark until the first frame wrap, then 12AF at full brightness.
    cycle(1'b1, 16'h12AF, 4'b0000, 4'b0000, 4'hF);
    idle(3 * N * S, 4'hF);

    // Mid-frame load must not tear the current frame.
    run_to_wrap(4'hF);
    idle(S + 2, 4'hF);
    cycle(1'b1, 16'h0000, 4'b0000, 4'b0000, 4'hF);
    idle(2 * N * S, 4'hF);

    // Load coinciding with the wrap cycle bypasses straight to active.
    cycle(1'b1, 16'h12AF, 4'b0000, 4'b0000, 4'hF);
    run_to_wrap(4'hF);
    cycle(1'b1, 16'h5555, 4'b0000, 4'b0000, 4'hF);
    idle(N * S + 2, 4'hF);

    // Brightness sweep over whole PWM periods.
    cycle(1'b1, 16'h12AF, 4'b0000, 4'b0000, 4'h4);
    idle(4 * N * S, 4'h4);
    idle(2 * N * S, 4'h0);
    idle(2 * N * S, 4'hF);

    // Per-digit blank and decimal point.
    cycle(1'b1, 16'h1234, 4'b0001, 4'b0100, 4'hF);
    idle(3 * N * S, 4'hF);

    // Zeros above the first nonzero digit.
    cycle(1'b1, 16'h0030, 4'b0000, 4'b0000, 4'hF);
    idle(3 * N * S, 4'hF);
    cycle(1'b1, 16'h0000, 4'b0100, 4'b0000, 4'hF);
    idle(3 * N * S, 4'hF);

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        cycle(1'b1, rand_digits(), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
              4'($urandom));
      end else begin
        idle(1, ($urandom_range(0, 3) == 0) ? 4'($urandom) : brightness);
      end
      if ($urandom_range(0, 63) == 0) begin
        run_to_wrap(brightness);
        cycle(1'b1, rand_digits(), 4'($urandom), 4'h0, brightness);
      end
    end

    // Reset mid-slot while a digit is lit; scanning restarts at digit 0.
    cycle(1'b1, 16'h9876, 4'b0010, 4'b0000, 4'hF);
    idle(N * S + S + 1, 4'hF);
    chk("lit_before_reset", (An != 4'hF), 1'b1);
    do_reset(1'b0);
    idle(N * S, 4'hF);
    cycle(1'b1, 16'hC0DE, 4'b1000, 4'b0000, 4'hF);
    idle(3 * N * S, 4'hF);
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 7) == 0), rand_digits(), 4'($urandom), 4'h0, 4'($urandom));
    end

    @(posedge board_clk);
    #3;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
